// File: rtl/lcd_regfile_pkg.sv
// Shared FSM state encodings and the address-width helper for the LCD shadow register file.
package lcd_regfile_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] OFFER = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/lcd_regfile_dirty_scanner.sv
// Flush-pass FSM: walks the dirty vector once, round-robin, and offers each dirty entry on a valid/ready link.
module lcd_dirty_scanner
  import lcd_regfile_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        flushReq,
  input  logic                        outReady,
  input  logic [DEPTH-1:0]            dirty,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  output logic                        busy,
  output logic                        outValid,
  output logic [ADDR_W-1:0]           outAddr,
  output logic [WIDTH-1:0]            outData,
  output logic                        clrEn,
  output logic [ADDR_W-1:0]           clrAddr
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] scanPtr, ptrNext;
  logic [ADDR_W:0]   visited, visNext;

  assign ptrNext  = (scanPtr == LAST) ? '0 : scanPtr + 1'b1;
  assign visNext  = visited + 1'b1;
  assign busy     = (state != IDLE);
  assign outValid = (state == OFFER);
  assign clrEn    = outValid && outReady;
  assign clrAddr  = outAddr;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      scanPtr <= '0;
      visited <= '0;
      outAddr <= '0;
      outData <= '0;
    end else begin
      case (state)
        IDLE: if (flushReq) begin
          state   <= SCAN;
          visited <= '0;
        end
        SCAN: if (dirty[scanPtr]) begin
          outAddr <= scanPtr;
          outData <= regs[scanPtr];
          state   <= OFFER;
        end else begin
          scanPtr <= ptrNext;
          visited <= visNext;
          if (visNext == DEPTH_L) state <= IDLE;
        end
        OFFER: if (outReady) begin
          scanPtr <= ptrNext;
          visited <= visNext;
          state   <= (visNext == DEPTH_L) ? IDLE : SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_shadow_register_file.sv
// Shadow register array with dirty tracking, registered read-first port and a dirty-entry flush stream.
module lcd_shadow_register_file
  import lcd_regfile_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [WIDTH-1:0]  rdData,
  input  logic              flushReq,
  output logic              busy,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outAddr,
  output logic [WIDTH-1:0]  outData,
  output logic [ADDR_W:0]   dirtyCount
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            dirty;
  logic                        wrHit, rdHit, clrEn, inc, dec;
  logic [ADDR_W-1:0]           clrAddr;

  assign wrHit = wrEn && ({1'b0, wrAddr} < DEPTH_L);
  assign rdHit = ({1'b0, rdAddr} < DEPTH_L);
  assign inc   = wrHit && !dirty[wrAddr];
  // A write landing on the entry being acknowledged keeps it dirty, so no decrement.
  assign dec   = clrEn && !(wrHit && (wrAddr == clrAddr));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      regs       <= '0;
      dirty      <= '0;
      rdData     <= '0;
      dirtyCount <= '0;
    end else begin
      rdData <= rdHit ? regs[rdAddr] : '0;
      if (wrHit) regs[wrAddr] <= wrData;
      if (clrEn) dirty[clrAddr] <= 1'b0;
      if (wrHit) dirty[wrAddr] <= 1'b1;
      case ({inc, dec})
        2'b10:   dirtyCount <= dirtyCount + 1'b1;
        2'b01:   dirtyCount <= dirtyCount - 1'b1;
        default: dirtyCount <= dirtyCount;
      endcase
    end
  end

  lcd_dirty_scanner #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uScanner (
    .clk      (clk),
    .resetN   (resetN),
    .flushReq (flushReq),
    .outReady (outReady),
    .dirty    (dirty),
    .regs     (regs),
    .busy     (busy),
    .outValid (outValid),
    .outAddr  (outAddr),
    .outData  (outData),
    .clrEn    (clrEn),
    .clrAddr  (clrAddr)
  );

endmodule

// File: tb/tb_lcd_shadow_register_file.sv
// Directed bench for lcd_shadow_register_file: reset, flush streaming, backpressure, races, read-first.
module tb_lcd_shadow_register_file;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              resetN;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [WIDTH-1:0]  wrData;
  logic [ADDR_W-1:0] rdAddr;
  logic [WIDTH-1:0]  rdData;
  logic              flushReq;
  logic              busy;
  logic              outValid;
  logic              outReady;
  logic [ADDR_W-1:0] outAddr;
  logic [WIDTH-1:0]  outData;
  logic [ADDR_W:0]   dirtyCount;

  int checks = 0;
  int errors = 0;

  int nBeats, nBusy;
  int bAddr [8];
  int bData [8];
  int bCnt  [8];

  always #5 clk = ~clk;

  lcd_shadow_register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetN(resetN), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddr(rdAddr), .rdData(rdData), .flushReq(flushReq), .busy(busy),
    .outValid(outValid), .outReady(outReady), .outAddr(outAddr), .outData(outData),
    .dirtyCount(dirtyCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input int a, input int d);
    wrEn = 1'b1; wrAddr = ADDR_W'(a); wrData = WIDTH'(d);
    tick();
    wrEn = 1'b0;
  endtask

  task automatic startFlush();
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
  endtask

  // Runs one pass, recording every handshake and the dirtyCount seen at that beat.
  task automatic flushCollect();
    int n;
    nBeats = 0; nBusy = 0; n = 0;
    startFlush();
    while (busy && n < 200) begin
      if (outValid && outReady && nBeats < 8) begin
        bAddr[nBeats] = int'(outAddr);
        bData[nBeats] = int'(outData);
        bCnt[nBeats]  = int'(dirtyCount);
        nBeats++;
      end
      nBusy++; n++;
      tick();
    end
    if (n >= 200) chk("flush_timeout", 32'd1, 32'd0);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!outValid && n < 100) begin n++; tick(); end
    if (n >= 100) chk("valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic stable;
    logic sawValid;
    resetN = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
    rdAddr = '0; flushReq = 1'b0; outReady = 1'b0;
    repeat (3) tick();
    resetN = 1'b1;
    tick();

    // Reset state
    chk("rst_rdData", 32'(rdData), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_outValid", 32'(outValid), 32'h0);
    chk("rst_dirtyCount", 32'(dirtyCount), 32'h0);
    chk("rst_outAddr", 32'(outAddr), 32'h0);

    // 1: empty flush -> busy 32 cycles, never valid
    outReady = 1'b1;
    sawValid = 1'b0;
    startFlush();
    nBusy = 0;
    while (busy && nBusy < 100) begin
      if (outValid) sawValid = 1'b1;
      nBusy++;
      tick();
    end
    chk("t1_busyCycles", 32'(nBusy), 32'd32);
    chk("t1_noValid", 32'(sawValid), 32'd0);
    chk("t1_dirtyCount", 32'(dirtyCount), 32'd0);

    // 2: two dirty entries stream in address order
    writeReg(3, 8'hF0);
    writeReg(17, 8'hF0);
    chk("t2_countPre", 32'(dirtyCount), 32'd2);
    flushCollect();
    chk("t2_beats", 32'(nBeats), 32'd2);
    chk("t2_addr0", 32'(bAddr[0]), 32'd3);
    chk("t2_data0", 32'(bData[0]), 32'hF0);
    chk("t2_cnt0", 32'(bCnt[0]), 32'd2);
    chk("t2_addr1", 32'(bAddr[1]), 32'd17);
    chk("t2_data1", 32'(bData[1]), 32'hF0);
    chk("t2_cnt1", 32'(bCnt[1]), 32'd1);
    chk("t2_countPost", 32'(dirtyCount), 32'd0);
    chk("t2_busyCycles", 32'(nBusy), 32'd34);

    // 3: backpressure holds the offer stable
    outReady = 1'b0;
    writeReg(5, 8'h5C);
    startFlush();
    waitValid();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!outValid || outAddr != 5'd5 || outData != 8'h5C) stable = 1'b0;
      tick();
    end
    chk("t3_stable", 32'(stable), 32'd1);
    outReady = 1'b1;
    tick();
    chk("t3_validDrop", 32'(outValid), 32'd0);
    waitIdle();
    chk("t3_countPost", 32'(dirtyCount), 32'd0);

    // 4: write on the handshake cycle to the offered entry
    outReady = 1'b0;
    writeReg(5, 8'h33);
    startFlush();
    waitValid();
    chk("t4_offerData", 32'(outData), 32'h33);
    wrEn = 1'b1; wrAddr = 5'd5; wrData = 8'hAA; outReady = 1'b1;
    tick();
    wrEn = 1'b0; outReady = 1'b0;
    chk("t4_countKept", 32'(dirtyCount), 32'd1);
    waitIdle();
    chk("t4_notResent", 32'(dirtyCount), 32'd1);
    outReady = 1'b1;
    flushCollect();
    chk("t4_beats", 32'(nBeats), 32'd1);
    chk("t4_addr", 32'(bAddr[0]), 32'd5);
    chk("t4_data", 32'(bData[0]), 32'hAA);
    chk("t4_countPost", 32'(dirtyCount), 32'd0);

    // 5: read-first on a same-cycle write
    writeReg(9, 8'h80);
    rdAddr = 5'd9;
    wrEn = 1'b1; wrAddr = 5'd9; wrData = 8'h11;
    tick();
    wrEn = 1'b0;
    chk("t5_readOld", 32'(rdData), 32'h80);
    tick();
    chk("t5_readNew", 32'(rdData), 32'h11);
    chk("t5_count", 32'(dirtyCount), 32'd1);
    rdAddr = 5'd3;
    tick();
    chk("t5_read3", 32'(rdData), 32'hF0);

    // 6: reset during an offer aborts everything
    outReady = 1'b0;
    startFlush();
    waitValid();
    chk("t6_offerAddr", 32'(outAddr), 32'd9);
    #1 resetN = 1'b0;
    #1;
    chk("t6_validRst", 32'(outValid), 32'd0);
    chk("t6_busyRst", 32'(busy), 32'd0);
    chk("t6_countRst", 32'(dirtyCount), 32'd0);
    chk("t6_rdDataRst", 32'(rdData), 32'd0);
    #1 resetN = 1'b1;
    tick();
    outReady = 1'b1;
    flushCollect();
    chk("t6_noBeats", 32'(nBeats), 32'd0);
    chk("t6_busyCycles", 32'(nBusy), 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
